// File: rtl/br_nzp_multi_if.sv
// Condition-code / branch-enable bus: command strobes from the control side,
// BEN and bank status back from the condition-code block.
interface br_nzp_multi_if #(
  parameter int WIDTH   = 16,
  parameter int NUM_CTX = 2
);
  localparam int CTX_W = (NUM_CTX > 1) ? $clog2(NUM_CTX) : 1;

  logic [WIDTH-1:0]   DataIn;
  logic               LDCC;
  logic [CTX_W-1:0]   CCCtx;
  logic               CCWrite;
  logic [2:0]         CCIn;
  logic               LDBEN;
  logic [CTX_W-1:0]   BenCtx;
  logic [2:0]         CondMask;
  logic [CTX_W-1:0]   RdCtx;
  logic               BEN;
  logic               BENValid;
  logic               BENErr;
  logic               CCErr;
  logic [2:0]         CCOut;
  logic [NUM_CTX-1:0] CCValid;

  modport master (
    output DataIn, LDCC, CCCtx, CCWrite, CCIn, LDBEN, BenCtx, CondMask, RdCtx,
    input  BEN, BENValid, BENErr, CCErr, CCOut, CCValid
  );

  modport slave (
    input  DataIn, LDCC, CCCtx, CCWrite, CCIn, LDBEN, BenCtx, CondMask, RdCtx,
    output BEN, BENValid, BENErr, CCErr, CCOut, CCValid
  );
endinterface

// File: rtl/br_nzp_multi.sv
// Multi-context NZP condition-code banks with a registered branch-enable that
// forwards a same-cycle bank write into the evaluation.
//
// Command semantics: LDCC, CCWrite and LDBEN are single-cycle strobes with no
// backpressure; each strobe is consumed on the clock edge where it is high.
// BENValid/BENErr/CCErr are one-cycle pulses reporting the previous strobe.
module br_nzp_multi #(
  parameter int WIDTH   = 16,
  parameter int NUM_CTX = 2
) (
  input logic           Clk,
  input logic           Reset,
  br_nzp_multi_if.slave bus
);
  localparam int CTX_W = (NUM_CTX > 1) ? $clog2(NUM_CTX) : 1;

  logic [2:0]         cc_q [NUM_CTX];
  logic [NUM_CTX-1:0] valid_q;
  logic               ben_q;
  logic               ben_valid_q;
  logic               ben_err_q;
  logic               cc_err_q;

  logic [2:0] gen_nzp;
  logic       cc_onehot;
  logic       ctx_ok;
  logic       wr_accept;
  logic [2:0] wr_val;
  logic       fwd;
  logic [2:0] ben_cc;
  logic       ben_vld;
  logic [2:0] eff_cc;
  logic       eff_vld;
  logic [2:0] cc_rd;

  always_comb begin
    gen_nzp   = 3'b001;
    cc_onehot = (bus.CCIn == 3'b100) || (bus.CCIn == 3'b010) || (bus.CCIn == 3'b001);
    if (bus.DataIn == '0)
      gen_nzp = 3'b010;
    else if (bus.DataIn[WIDTH-1])
      gen_nzp = 3'b100;
  end

  // Index decode by loop so out-of-range contexts simply match nothing.
  always_comb begin
    ctx_ok  = 1'b0;
    ben_cc  = 3'b000;
    ben_vld = 1'b0;
    cc_rd   = 3'b000;
    for (int i = 0; i < NUM_CTX; i++) begin
      if (bus.CCCtx == CTX_W'(i))
        ctx_ok = 1'b1;
      if (bus.BenCtx == CTX_W'(i)) begin
        ben_cc  = cc_q[i];
        ben_vld = valid_q[i];
      end
      if (bus.RdCtx == CTX_W'(i))
        cc_rd = cc_q[i];
    end
  end

  // A CCWrite claims the cycle even when rejected, blocking LDCC.
  always_comb begin
    wr_val    = bus.CCWrite ? bus.CCIn : gen_nzp;
    wr_accept = ctx_ok && (bus.CCWrite ? cc_onehot : bus.LDCC);
    fwd       = wr_accept && (bus.CCCtx == bus.BenCtx);
    eff_cc    = fwd ? wr_val : ben_cc;
    eff_vld   = fwd || ben_vld;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int i = 0; i < NUM_CTX; i++)
        cc_q[i] <= 3'b000;
      valid_q     <= '0;
      ben_q       <= 1'b0;
      ben_valid_q <= 1'b0;
      ben_err_q   <= 1'b0;
      cc_err_q    <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_CTX; i++) begin
        if (wr_accept && (bus.CCCtx == CTX_W'(i))) begin
          cc_q[i]    <= wr_val;
          valid_q[i] <= 1'b1;
        end
      end
      ben_valid_q <= bus.LDBEN;
      ben_err_q   <= bus.LDBEN && (bus.CondMask != 3'b111) &&
                     (bus.CondMask != 3'b000) && !eff_vld;
      cc_err_q    <= bus.CCWrite && ctx_ok && !cc_onehot;
      // Mask 111 branches unconditionally; otherwise an invalid bank yields 0.
      if (bus.LDBEN)
        ben_q <= (bus.CondMask == 3'b111) || (eff_vld && |(bus.CondMask & eff_cc));
    end
  end

  assign bus.BEN      = ben_q;
  assign bus.BENValid = ben_valid_q;
  assign bus.BENErr   = ben_err_q;
  assign bus.CCErr    = cc_err_q;
  assign bus.CCOut    = cc_rd;
  assign bus.CCValid  = valid_q;
endmodule

// File: tb/tb_br_nzp_multi.sv
// Directed bench for br_nzp_multi: default 16-bit/2-context instance plus a
// 32-bit/4-context instance for the wide-bus and higher-context cases.
module tb_br_nzp_multi;
  logic Clk;
  logic Reset;
  int   checks;
  int   errors;

  br_nzp_multi_if #(.WIDTH(16), .NUM_CTX(2)) b0 ();
  br_nzp_multi_if #(.WIDTH(32), .NUM_CTX(4)) b1 ();

  br_nzp_multi #(.WIDTH(16), .NUM_CTX(2)) dut0 (.Clk(Clk), .Reset(Reset), .bus(b0));
  br_nzp_multi #(.WIDTH(32), .NUM_CTX(4)) dut1 (.Clk(Clk), .Reset(Reset), .bus(b1));

  // Clock / reset
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic idle0();
    b0.LDCC = 0; b0.CCWrite = 0; b0.LDBEN = 0; b0.DataIn = '0; b0.CCIn = '0;
    b0.CCCtx = '0; b0.BenCtx = '0; b0.CondMask = '0;
  endtask

  task automatic idle1();
    b1.LDCC = 0; b1.CCWrite = 0; b1.LDBEN = 0; b1.DataIn = '0; b1.CCIn = '0;
    b1.CCCtx = '0; b1.BenCtx = '0; b1.CondMask = '0;
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    step();
    step();
    Reset = 1'b0;
    checks++; if (b0.BEN !== 1'b0) begin errors++; $display("FAIL reset_ben got %b want 0", b0.BEN); end
    checks++; if (b0.BENValid !== 1'b0) begin errors++; $display("FAIL reset_benvalid got %b want 0", b0.BENValid); end
    checks++; if (b0.BENErr !== 1'b0) begin errors++; $display("FAIL reset_benerr got %b want 0", b0.BENErr); end
    checks++; if (b0.CCErr !== 1'b0) begin errors++; $display("FAIL reset_ccerr got %b want 0", b0.CCErr); end
    checks++; if (b0.CCValid !== 2'b00) begin errors++; $display("FAIL reset_ccvalid got %b want 00", b0.CCValid); end
    checks++; if (b0.CCOut !== 3'b000) begin errors++; $display("FAIL reset_ccout got %b want 000", b0.CCOut); end
    checks++; if (b1.CCValid !== 4'b0000) begin errors++; $display("FAIL reset_ccvalid_w got %b want 0000", b1.CCValid); end
  endtask

  task automatic test_unloaded();
    b0.LDBEN = 1; b0.BenCtx = 0; b0.CondMask = 3'b010;
    step();
    idle0();
    checks++; if (b0.BEN !== 1'b0) begin errors++; $display("FAIL unl_ben got %b want 0", b0.BEN); end
    checks++; if (b0.BENValid !== 1'b1) begin errors++; $display("FAIL unl_benvalid got %b want 1", b0.BENValid); end
    checks++; if (b0.BENErr !== 1'b1) begin errors++; $display("FAIL unl_benerr got %b want 1", b0.BENErr); end
    checks++; if (b0.CCValid !== 2'b00) begin errors++; $display("FAIL unl_ccvalid got %b want 00", b0.CCValid); end
    step();
    checks++; if (b0.BENValid !== 1'b0) begin errors++; $display("FAIL unl_pulse_valid got %b want 0", b0.BENValid); end
    checks++; if (b0.BENErr !== 1'b0) begin errors++; $display("FAIL unl_pulse_err got %b want 0", b0.BENErr); end
    // unconditional mask on an unloaded bank
    b0.LDBEN = 1; b0.BenCtx = 1; b0.CondMask = 3'b111;
    step();
    idle0();
    checks++; if (b0.BEN !== 1'b1) begin errors++; $display("FAIL m111_ben got %b want 1", b0.BEN); end
    checks++; if (b0.BENErr !== 1'b0) begin errors++; $display("FAIL m111_benerr got %b want 0", b0.BENErr); end
  endtask

  task automatic test_load_eval();
    b0.LDCC = 1; b0.CCCtx = 1; b0.DataIn = 16'h8000;
    step();
    idle0();
    b0.RdCtx = 1; #1;
    checks++; if (b0.CCOut !== 3'b100) begin errors++; $display("FAIL ld_ccout1 got %b want 100", b0.CCOut); end
    checks++; if (b0.CCValid !== 2'b10) begin errors++; $display("FAIL ld_ccvalid got %b want 10", b0.CCValid); end
    b0.RdCtx = 0; #1;
    checks++; if (b0.CCOut !== 3'b000) begin errors++; $display("FAIL ld_ccout0 got %b want 000", b0.CCOut); end
    b0.LDBEN = 1; b0.BenCtx = 1; b0.CondMask = 3'b100;
    step();
    checks++; if (b0.BEN !== 1'b1) begin errors++; $display("FAIL ld_ben_n got %b want 1", b0.BEN); end
    checks++; if (b0.BENErr !== 1'b0) begin errors++; $display("FAIL ld_benerr got %b want 0", b0.BENErr); end
    b0.CondMask = 3'b011;
    step();
    idle0();
    checks++; if (b0.BEN !== 1'b0) begin errors++; $display("FAIL ld_ben_zp got %b want 0", b0.BEN); end
    checks++; if (b0.BENValid !== 1'b1) begin errors++; $display("FAIL ld_benvalid got %b want 1", b0.BENValid); end
  endtask

  task automatic test_forward();
    b0.LDCC = 1; b0.CCCtx = 0; b0.DataIn = 16'h0005;
    step();
    idle0();
    b0.RdCtx = 0; #1;
    checks++; if (b0.CCOut !== 3'b001) begin errors++; $display("FAIL fw_pre_ccout got %b want 001", b0.CCOut); end
    b0.LDCC = 1; b0.CCCtx = 0; b0.DataIn = 16'h0000;
    b0.LDBEN = 1; b0.BenCtx = 0; b0.CondMask = 3'b010;
    step();
    idle0();
    checks++; if (b0.BEN !== 1'b1) begin errors++; $display("FAIL fw_ben got %b want 1", b0.BEN); end
    checks++; if (b0.BENErr !== 1'b0) begin errors++; $display("FAIL fw_benerr got %b want 0", b0.BENErr); end
    checks++; if (b0.CCOut !== 3'b010) begin errors++; $display("FAIL fw_ccout got %b want 010", b0.CCOut); end
  endtask

  task automatic test_ccwrite();
    b0.CCWrite = 1; b0.CCIn = 3'b011; b0.LDCC = 1; b0.DataIn = 16'h0005; b0.CCCtx = 0;
    step();
    idle0();
    b0.RdCtx = 0; #1;
    checks++; if (b0.CCErr !== 1'b1) begin errors++; $display("FAIL cw_ccerr got %b want 1", b0.CCErr); end
    checks++; if (b0.CCOut !== 3'b010) begin errors++; $display("FAIL cw_rej_ccout got %b want 010", b0.CCOut); end
    checks++; if (b0.CCValid !== 2'b11) begin errors++; $display("FAIL cw_rej_ccvalid got %b want 11", b0.CCValid); end
    checks++; if (b0.BEN !== 1'b1) begin errors++; $display("FAIL cw_ben_hold got %b want 1", b0.BEN); end
    b0.CCWrite = 1; b0.CCIn = 3'b100; b0.CCCtx = 0;
    step();
    idle0();
    checks++; if (b0.CCErr !== 1'b0) begin errors++; $display("FAIL cw_ok_ccerr got %b want 0", b0.CCErr); end
    checks++; if (b0.CCOut !== 3'b100) begin errors++; $display("FAIL cw_ok_ccout got %b want 100", b0.CCOut); end
    checks++; if (b0.CCValid[0] !== 1'b1) begin errors++; $display("FAIL cw_ok_valid got %b want 1", b0.CCValid[0]); end
    b0.LDBEN = 1; b0.BenCtx = 0; b0.CondMask = 3'b000;
    step();
    idle0();
    checks++; if (b0.BEN !== 1'b0) begin errors++; $display("FAIL m000_ben got %b want 0", b0.BEN); end
    checks++; if (b0.BENErr !== 1'b0) begin errors++; $display("FAIL m000_benerr got %b want 0", b0.BENErr); end
  endtask

  task automatic test_back_to_back();
    // ctx0 = 100, ctx1 = 100 at this point
    b0.LDBEN = 1; b0.BenCtx = 0; b0.CondMask = 3'b100;
    step();
    checks++; if (b0.BEN !== 1'b1 || b0.BENValid !== 1'b1) begin errors++; $display("FAIL b2b_0 got ben=%b vld=%b want 1 1", b0.BEN, b0.BENValid); end
    b0.BenCtx = 1; b0.CondMask = 3'b001;
    step();
    checks++; if (b0.BEN !== 1'b0 || b0.BENValid !== 1'b1) begin errors++; $display("FAIL b2b_1 got ben=%b vld=%b want 0 1", b0.BEN, b0.BENValid); end
    b0.BenCtx = 0; b0.CondMask = 3'b110;
    step();
    idle0();
    checks++; if (b0.BEN !== 1'b1 || b0.BENValid !== 1'b1) begin errors++; $display("FAIL b2b_2 got ben=%b vld=%b want 1 1", b0.BEN, b0.BENValid); end
    step();
    checks++; if (b0.BEN !== 1'b1 || b0.BENValid !== 1'b0) begin errors++; $display("FAIL b2b_idle got ben=%b vld=%b want 1 0", b0.BEN, b0.BENValid); end
  endtask

  task automatic test_reset_mid();
    b0.LDBEN = 1; b0.BenCtx = 0; b0.CondMask = 3'b100;
    b0.LDCC = 1; b0.CCCtx = 1; b0.DataIn = 16'h0001;
    Reset = 1'b1;
    step();
    Reset = 1'b0;
    idle0();
    b0.RdCtx = 0; #1;
    checks++; if (b0.CCOut !== 3'b000) begin errors++; $display("FAIL rm_ccout0 got %b want 000", b0.CCOut); end
    b0.RdCtx = 1; #1;
    checks++; if (b0.CCOut !== 3'b000) begin errors++; $display("FAIL rm_ccout1 got %b want 000", b0.CCOut); end
    checks++; if (b0.CCValid !== 2'b00) begin errors++; $display("FAIL rm_ccvalid got %b want 00", b0.CCValid); end
    checks++; if (b0.BEN !== 1'b0) begin errors++; $display("FAIL rm_ben got %b want 0", b0.BEN); end
    checks++; if (b0.BENValid !== 1'b0) begin errors++; $display("FAIL rm_benvalid got %b want 0", b0.BENValid); end
  endtask

  task automatic test_wide();
    b1.LDCC = 1; b1.CCCtx = 3; b1.DataIn = 32'h8000_0000;
    step();
    idle1();
    b1.RdCtx = 3; #1;
    checks++; if (b1.CCOut !== 3'b100) begin errors++; $display("FAIL w_ccout3 got %b want 100", b1.CCOut); end
    checks++; if (b1.CCValid !== 4'b1000) begin errors++; $display("FAIL w_ccvalid got %b want 1000", b1.CCValid); end
    b1.LDCC = 1; b1.CCCtx = 2; b1.DataIn = 32'h7fff_ffff;
    b1.LDBEN = 1; b1.BenCtx = 3; b1.CondMask = 3'b100;
    step();
    idle1();
    checks++; if (b1.BEN !== 1'b1) begin errors++; $display("FAIL w_ben got %b want 1", b1.BEN); end
    b1.RdCtx = 2; #1;
    checks++; if (b1.CCOut !== 3'b001) begin errors++; $display("FAIL w_ccout2 got %b want 001", b1.CCOut); end
    b1.LDBEN = 1; b1.BenCtx = 3; b1.CondMask = 3'b100;
    Reset = 1'b1;
    step();
    Reset = 1'b0;
    idle1();
    b1.RdCtx = 3; #1;
    checks++; if (b1.CCOut !== 3'b000) begin errors++; $display("FAIL w_rst_ccout got %b want 000", b1.CCOut); end
    checks++; if (b1.CCValid !== 4'b0000) begin errors++; $display("FAIL w_rst_ccvalid got %b want 0000", b1.CCValid); end
    checks++; if (b1.BEN !== 1'b0 || b1.BENValid !== 1'b0) begin errors++; $display("FAIL w_rst_ben got ben=%b vld=%b want 0 0", b1.BEN, b1.BENValid); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    Reset  = 1'b1;
    idle0();
    idle1();
    b0.RdCtx = '0;
    b1.RdCtx = '0;
    test_reset();
    test_unloaded();
    test_load_eval();
    test_forward();
    test_ccwrite();
    test_back_to_back();
    test_reset_mid();
    test_wide();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/br_nzp_multi.md
Name: br_nzp_multi

Overview:
- Parametrised successor to the single-bank NZP/BEN logic in the LC-3 datapath.
- Holds NUM_CTX independent condition-code banks (one per context), generated from a WIDTH-bit result bus or restored directly from a PSR image.
- Evaluates a registered branch-enable against a selected bank, with same-cycle write forwarding, a bank-valid scoreboard and error flags.
- Sits between the bus/ALU result path and the control FSM.

Parameters:
- WIDTH, 16, width of DataIn; sign bit is DataIn[WIDTH-1].
- NUM_CTX, 2, number of CC banks (>=1).
- CTX_W, max(1,$clog2(NUM_CTX)), context index width (localparam, derived).

Ports:
- Clk  in  1  system clock
- Reset  in  1  synchronous, active-high reset
- DataIn  in  WIDTH  result value used to generate NZP
- LDCC  in  1  load NZP from DataIn into bank CCCtx
- CCCtx  in  CTX_W  bank written by LDCC/CCWrite
- CCWrite  in  1  direct restore of bank CCCtx from CCIn
- CCIn  in  3  restore value {N,Z,P}
- LDBEN  in  1  evaluate branch enable
- BenCtx  in  CTX_W  bank evaluated by LDBEN
- CondMask  in  3  {n,z,p} branch condition (IR[11:9])
- RdCtx  in  CTX_W  bank shown on CCOut
- BEN  out  1  registered branch enable
- BENValid  out  1  one-cycle pulse: BEN updated this cycle
- BENErr  out  1  one-cycle pulse: evaluated an unloaded bank
- CCErr  out  1  one-cycle pulse: CCWrite rejected
- CCOut  out  3  stored NZP of bank RdCtx (combinational read)
- CCValid  out  NUM_CTX  per-bank loaded flag

Behaviour:
- Reset (wins over everything in the same cycle):
  - all banks 3'b000, CCValid 0, BEN 0, BENValid 0, BENErr 0, CCErr 0.
- NZP generation:
  - DataIn==0 -> 010; else DataIn[WIDTH-1]==1 -> 100; else 001.
  - Result is always one-hot.
- Bank write, 1-cycle latency; visible on CCOut/CCValid the cycle after:
  - CCWrite with one-hot CCIn -> bank CCCtx <= CCIn, CCValid[CCCtx] <= 1.
  - CCWrite with non-one-hot CCIn (000, 011, 111, ...) -> bank unchanged, CCErr pulses next cycle.
  - LDCC -> bank CCCtx <= generated NZP, CCValid[CCCtx] <= 1.
  - CCWrite and LDCC in the same cycle: CCWrite has priority, even if rejected (a rejected CCWrite suppresses LDCC that cycle).
  - CCCtx >= NUM_CTX: write ignored, no error.
- Effective bank value:
  - the value being written this cycle to BenCtx if a write to BenCtx is accepted; otherwise the stored value.
  - This forwarding is required: LDCC+LDBEN in one cycle must use the new CC.
- Branch evaluation, registered, 1-cycle latency:
  - On LDBEN: BEN <= |(CondMask & effective NZP); BENValid pulses next cycle.
  - CondMask==111: BEN <= 1 regardless of validity, no BENErr.
  - CondMask==000: BEN <= 0, no BENErr.
  - Any other mask with bank invalid and not written this cycle: BEN <= 0, BENErr pulses.
  - BenCtx >= NUM_CTX is treated as invalid.
  - Without LDBEN, BEN holds its value; BENValid/BENErr are 0.
- Back-to-back LDBEN every cycle is supported; each produces its own BENValid pulse.
- CCOut: RdCtx out of range -> 000.
- No internal FSM beyond the per-bank registers, valid scoreboard and BEN/flag registers. All outputs are registered except CCOut.

Test Plan:
- Reset, then LDBEN with CondMask=010 on ctx0 -> next cycle BEN=0, BENValid=1, BENErr=1; CCValid=00.
- LDCC with DataIn=16'h8000 to ctx1; next cycle LDBEN with BenCtx=1, CondMask=100 -> BEN=1; then CondMask=011 -> BEN=0; CCOut (RdCtx=1)=100; ctx0 is unchanged.
- Same-cycle LDCC (DataIn=0, ctx0) and LDBEN (ctx0, CondMask=010), with ctx0 previously 001 -> BEN=1 (forwarded); CCOut=010 the cycle after.
- CCWrite ctx0 CCIn=011 together with LDCC DataIn=5 -> bank unchanged, CCErr=1, CCValid[0] unchanged; then CCWrite CCIn=100 -> bank=100, CCValid[0]=1.
- CondMask=111 on an unloaded bank -> BEN=1, BENErr=0. CondMask=000 on a loaded bank -> BEN=0.
- Assert Reset in the same cycle as LDBEN and LDCC after loaded state -> next cycle all banks 000, CCValid 0, BEN 0, BENValid 0. Repeat with WIDTH=32, NUM_CTX=4, DataIn=32'h80000000 on ctx3 -> CCOut(RdCtx=3)=100.
